// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the timer scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_sched_pkg;

  localparam int DELAY_W               = 32;
  localparam int DEFAULT_TIMEOUT_SLACK = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SETTLE,
    WAIT,
    DONE,
    ABORT
  } sched_state_t;

endpackage

// File: rtl/timer_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          gnt_vld
);

  logic [IW-1:0] idx;
  logic          found;

  // Walk the ring once starting at ptr and take the first live request.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
      idx = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
    end
  end

  assign gnt_vld = found;

endmodule

// File: rtl/timer_scheduler.sv
// Shares one external countdown timer among NUM_REQ requesters, one job at a time.
// Latency: grant+arm 1 cycle after request, done 1 cycle after expiry seen in WAIT; D=0 completes in 1 cycle.
// Backpressure: requesters hold req_valid until their req_ready pulse; requests are ignored while busy.
// Optional: define TIMER_SCHED_WATCHDOG_EN to abort jobs whose expiry never arrives (err pulse).
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int TIMEOUT_SLACK = DEFAULT_TIMEOUT_SLACK
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DELAY_W-1:0]   req_delay,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           done,
  output logic [NUM_REQ-1:0]           err,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic [DELAY_W-1:0]           tmr_set_val,
  output logic                         tmr_set,
  input  logic                         tmr_is_high
);

  localparam int IDW = $clog2(NUM_REQ);

  sched_state_t       state;
  logic [IDW-1:0]     rr_ptr;
  logic [NUM_REQ-1:0] owner_oh;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDW-1:0]     arb_id;
  logic               arb_vld;
  logic [DELAY_W-1:0] sel_delay;

`ifdef TIMER_SCHED_WATCHDOG_EN
  logic [DELAY_W-1:0] delay_q;
  logic [DELAY_W:0]   wd_cnt;
  logic [DELAY_W:0]   wd_limit;
  logic [NUM_REQ-1:0] err_q;

  // 33-bit limit so D near 2^32 plus slack cannot wrap to a short timeout.
  assign wd_limit = {1'b0, delay_q} + (DELAY_W+1)'(TIMEOUT_SLACK);
  assign err      = err_q;
`else
  assign err = '0;

  // Slack only matters when the watchdog is built in.
  if (TIMEOUT_SLACK < 0) begin : g_slack_unused
  end
`endif

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_id  (arb_id),
    .gnt_vld (arb_vld)
  );

  // Pick the winner's delay slice out of the flat request bus.
  always_comb begin
    sel_delay = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) sel_delay = req_delay[i*DELAY_W +: DELAY_W];
    end
  end

  // Job FSM; every output is a register so pulses line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner_oh    <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      req_ready   <= '0;
      done        <= '0;
      tmr_set     <= 1'b0;
      tmr_set_val <= '0;
`ifdef TIMER_SCHED_WATCHDOG_EN
      delay_q     <= '0;
      wd_cnt      <= '0;
      err_q       <= '0;
`endif
    end else begin
      req_ready <= '0;
      done      <= '0;
      tmr_set   <= 1'b0;
`ifdef TIMER_SCHED_WATCHDOG_EN
      err_q     <= '0;
`endif
      case (state)
        IDLE: begin
          if (arb_vld) begin
            grant_id  <= arb_id;
            owner_oh  <= arb_gnt;
            rr_ptr    <= (arb_id == IDW'(NUM_REQ - 1)) ? '0 : arb_id + IDW'(1);
            busy      <= 1'b1;
            req_ready <= arb_gnt;
`ifdef TIMER_SCHED_WATCHDOG_EN
            delay_q   <= sel_delay;
`endif
            if (sel_delay == '0) begin
              // Zero delay never touches the timer; accept and finish together.
              state <= DONE;
              done  <= arb_gnt;
            end else begin
              state       <= ARM;
              tmr_set     <= 1'b1;
              tmr_set_val <= sel_delay;
            end
          end
        end
        ARM: begin
          state <= SETTLE;
        end
        SETTLE: begin
          // The timer may still show the previous job's expiry here; skip it.
          state <= WAIT;
`ifdef TIMER_SCHED_WATCHDOG_EN
          wd_cnt <= '0;
`endif
        end
        WAIT: begin
          if (tmr_is_high) begin
            state <= DONE;
            done  <= owner_oh;
          end
`ifdef TIMER_SCHED_WATCHDOG_EN
          else if (wd_cnt + (DELAY_W+1)'(1) >= wd_limit) begin
            state <= ABORT;
            err_q <= owner_oh;
          end else begin
            wd_cnt <= wd_cnt + (DELAY_W+1)'(1);
          end
`endif
        end
        DONE, ABORT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
